// File: rtl/k_syncfifo_param.sv
// Single-clock parametrised FIFO with first-word fall-through read, occupancy count and status flags; 1-cycle write-to-read and status latency.
// Backpressure: wrdy=0 when full, rrdy=0 when empty; refused accesses only set the sticky ovf/udf flags.
module k_syncfifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wput,
    output logic                     wrdy,
    output logic [DATA_W-1:0]        rdata,
    input  logic                     rget,
    output logic                     rrdy,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     afull,
    output logic                     aempty,
    output logic                     ovf,
    output logic                     udf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("k_syncfifo_param: DEPTH must be a power of two and at least 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("k_syncfifo_param: AF_LEVEL must lie in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("k_syncfifo_param: AE_LEVEL must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW-1:0]     r_count;
    logic              r_ovf;
    logic              r_udf;

    logic              w_full;
    logic              w_empty;
    logic              w_wacc;
    logic              w_racc;

    // Status is decoded from the count register only, so no input reaches a status output combinationally.
    assign w_full  = (r_count == PW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wacc  = wput & ~w_full  & ~flush;
    assign w_racc  = rget & ~w_empty & ~flush;

    assign wrdy   = ~w_full;
    assign rrdy   = ~w_empty;
    assign count  = r_count;
    assign afull  = (r_count >= PW'(AF_LEVEL));
    assign aempty = (r_count <= PW'(AE_LEVEL));
    assign ovf    = r_ovf;
    assign udf    = r_udf;
    assign rdata  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wacc) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wacc) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_racc) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (wput & w_full) begin
                r_ovf <= 1'b1;
            end
            if (rget & w_empty) begin
                r_udf <= 1'b1;
            end
            if (w_wacc & ~w_racc) begin
                r_count <= r_count + PW'(1);
            end else if (w_racc & ~w_wacc) begin
                r_count <= r_count - PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_k_syncfifo_param.sv
// Bench for k_syncfifo_param: directed fill/drain/boundary/flush/reset sequences plus random traffic on
// three parameter sets, each checked every cycle against a queue-based reference model.
module tb_k_syncfifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Main instance: DEPTH=16, AF_LEVEL=14, AE_LEVEL=1
    logic [7:0] wdata, rdata;
    logic       wput, rget, flush;
    logic       wrdy, rrdy, afull, aempty, ovf, udf;
    logic [4:0] count;

    k_syncfifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(1)) u_dut (
        .clk(clk), .rst(rst), .wdata(wdata), .wput(wput), .wrdy(wrdy), .rdata(rdata),
        .rget(rget), .rrdy(rrdy), .flush(flush), .count(count), .afull(afull),
        .aempty(aempty), .ovf(ovf), .udf(udf)
    );

    // Reference model: the FIFO is just a queue; its size is the occupancy.
    logic [7:0] q[$];
    bit m_ovf, m_udf, m_wa, m_ra;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        chk("m.count",  64'(count),  64'(q.size()));
        chk("m.wrdy",   64'(wrdy),   64'(q.size() != 16));
        chk("m.rrdy",   64'(rrdy),   64'(q.size() != 0));
        chk("m.afull",  64'(afull),  64'(q.size() >= 14));
        chk("m.aempty", 64'(aempty), 64'(q.size() <= 1));
        chk("m.ovf",    64'(ovf),    64'(m_ovf));
        chk("m.udf",    64'(udf),    64'(m_udf));
        if (q.size() != 0) chk("m.rdata", 64'(rdata), 64'(q[0]));
        if (!rst) begin
            if (flush) begin
                q.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                m_wa = wput && (q.size() != 16);
                m_ra = rget && (q.size() != 0);
                if (wput && q.size() == 16) m_ovf = 1'b1;
                if (rget && q.size() == 0)  m_udf = 1'b1;
                if (m_ra) void'(q.pop_front());
                if (m_wa) q.push_back(wdata);
            end
        end
    end

    task automatic step(input bit wp, input bit rg, input bit fl, input logic [7:0] d);
        wput  = wp;
        rget  = rg;
        flush = fl;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    // Parameter sweep instances with their own random traffic and reference queues
    for (genvar g = 0; g < 2; g++) begin : gs
        localparam int DW = (g == 0) ? 1 : 32;
        localparam int DP = (g == 0) ? 2 : 64;
        localparam int AF = (DP > 2) ? DP - 2 : 1;
        localparam int CW = $clog2(DP) + 1;

        logic [DW-1:0] s_wdata, s_rdata;
        logic          s_wput, s_rget, s_flush;
        logic          s_wrdy, s_rrdy, s_afull, s_aempty, s_ovf, s_udf;
        logic [CW-1:0] s_count;
        logic          sw_done;
        logic [31:0]   sq[$];
        bit            sm_ovf, sm_udf, sm_wa, sm_ra;

        k_syncfifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(1)) u_dut (
            .clk(clk), .rst(rst), .wdata(s_wdata), .wput(s_wput), .wrdy(s_wrdy), .rdata(s_rdata),
            .rget(s_rget), .rrdy(s_rrdy), .flush(s_flush), .count(s_count), .afull(s_afull),
            .aempty(s_aempty), .ovf(s_ovf), .udf(s_udf)
        );

        initial begin
            sw_done = 1'b0;
            s_wput  = 1'b0;
            s_rget  = 1'b0;
            s_flush = 1'b0;
            s_wdata = '0;
            wait (rst == 1'b0);
            @(posedge clk);
            #1;
            for (int i = 0; i < 10000; i++) begin
                s_wput  = 1'($urandom_range(0, 1));
                s_rget  = 1'($urandom_range(0, 1));
                s_flush = ($urandom_range(0, 63) == 0);
                s_wdata = DW'($urandom);
                @(posedge clk);
                #1;
            end
            s_wput  = 1'b0;
            s_rget  = 1'b0;
            s_flush = 1'b0;
            sw_done = 1'b1;
        end

        always @(negedge clk) begin
            if (rst) begin
                sq.delete();
                sm_ovf = 1'b0;
                sm_udf = 1'b0;
            end
            chk($sformatf("sw%0d.count", g),  64'(s_count),  64'(sq.size()));
            chk($sformatf("sw%0d.wrdy", g),   64'(s_wrdy),   64'(sq.size() != DP));
            chk($sformatf("sw%0d.rrdy", g),   64'(s_rrdy),   64'(sq.size() != 0));
            chk($sformatf("sw%0d.afull", g),  64'(s_afull),  64'(sq.size() >= AF));
            chk($sformatf("sw%0d.aempty", g), 64'(s_aempty), 64'(sq.size() <= 1));
            chk($sformatf("sw%0d.ovf", g),    64'(s_ovf),    64'(sm_ovf));
            chk($sformatf("sw%0d.udf", g),    64'(s_udf),    64'(sm_udf));
            if (sq.size() != 0) chk($sformatf("sw%0d.rdata", g), 64'(s_rdata), 64'(sq[0]));
            if (!rst) begin
                if (s_flush) begin
                    sq.delete();
                    sm_ovf = 1'b0;
                    sm_udf = 1'b0;
                end else begin
                    sm_wa = s_wput && (sq.size() != DP);
                    sm_ra = s_rget && (sq.size() != 0);
                    if (s_wput && sq.size() == DP) sm_ovf = 1'b1;
                    if (s_rget && sq.size() == 0)  sm_udf = 1'b1;
                    if (sm_ra) void'(sq.pop_front());
                    if (sm_wa) sq.push_back(32'(s_wdata));
                end
            end
        end
    end

    initial begin
        wput  = 1'b0;
        rget  = 1'b0;
        flush = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill 0x00..0x0F, then full with both requests: read taken, write refused
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("full_rw.count", 64'(count), 64'd15);
        chk("full_rw.ovf",   64'(ovf),   64'd1);

        // Drain, then empty with both requests: write taken, read refused
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h5A);
        chk("empty_rw.count", 64'(count), 64'd1);
        chk("empty_rw.udf",   64'(udf),   64'd1);
        chk("empty_rw.rdata", 64'(rdata), 64'h5A);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Flush at count=9 with sticky errors set, colliding with wput/rget
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        chk("pre_flush.count", 64'(count), 64'd9);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.rrdy",  64'(rrdy),  64'd0);
        chk("flush.ovf",   64'(ovf),   64'd0);
        chk("flush.udf",   64'(udf),   64'd0);
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        chk("post_flush.rdata", 64'(rdata), 64'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Wrap-around: hold occupancy at 8 with simultaneous traffic
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h50 + i));
        chk("wrap.count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++)  step(1'b0, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset in the middle of a burst at count=5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        #2;
        rst  = 1'b1;
        wput = 1'b0;
        #1;
        chk("arst.wrdy",   64'(wrdy),   64'd1);
        chk("arst.rrdy",   64'(rrdy),   64'd0);
        chk("arst.count",  64'(count),  64'd0);
        chk("arst.aempty", 64'(aempty), 64'd1);
        chk("arst.afull",  64'(afull),  64'd0);
        chk("arst.ovf",    64'(ovf),    64'd0);
        chk("arst.udf",    64'(udf),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic: write-heavy first half to reach full, read-heavy second half
        for (int i = 0; i < 10200; i++) begin
            step(1'($urandom_range(0, 3) < ((i < 5000) ? 3 : 1)),
                 1'($urandom_range(0, 3) < ((i < 5000) ? 1 : 3)),
                 ($urandom_range(0, 31) == 0),
                 8'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);

        begin : wait_sweeps
            int budget;
            budget = 1000;
            while (!(gs[0].sw_done && gs[1].sw_done) && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            chk("sweep_done", 64'(gs[0].sw_done && gs[1].sw_done), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
